// File: rtl/song_sequencer_pkg.sv
// Shared widths, state encoding and word helpers for the song sequencer slice.
package song_sequencer_pkg;

  localparam int NOTE_W = 6;
  localparam int DUR_W  = 6;
  localparam int SONG_W = 2;
  localparam int IDX_W  = 5;
  localparam int WORD_W = NOTE_W + DUR_W;
  localparam int ADDR_W = SONG_W + IDX_W;

  // Last addressable word of a song; reaching it ends the song even without a terminator.
  localparam logic [IDX_W-1:0] IDX_LAST = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD_WAIT,
    S_CLR_WAIT,
    S_PLAYING,
    S_ADVANCE,
    S_DONE
  } state_t;

  // A zero duration marks the end of a song.
  function automatic logic is_terminator(input logic [WORD_W-1:0] word);
    return word[DUR_W-1:0] == '0;
  endfunction

  function automatic logic [WORD_W-1:0] make_word(input logic [NOTE_W-1:0] note,
                                                  input logic [DUR_W-1:0]  dur);
    return {note, dur};
  endfunction

endpackage

// File: rtl/song_sequencer_rom.sv
// Song book: four songs of 32 (note, duration) words, synchronous read with one cycle latency.
module song_rom
  import song_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  output logic [WORD_W-1:0] dout
);

  logic [WORD_W-1:0] word_d;
  logic [WORD_W-1:0] dout_q;

  // Table lookup; song 1 is a full 32-word song without a terminator, built from its index.
  always_comb begin
    word_d = '0;
    case (addr)
      7'h00:   word_d = make_word(6'd10, 6'd4);
      7'h01:   word_d = make_word(6'd20, 6'd2);
      7'h02:   word_d = make_word(6'd0,  6'd0);
      7'h40:   word_d = make_word(6'd30, 6'd3);
      7'h41:   word_d = make_word(6'd31, 6'd5);
      7'h42:   word_d = make_word(6'd32, 6'd1);
      7'h43:   word_d = make_word(6'd33, 6'd0);
      7'h60:   word_d = make_word(6'd40, 6'd7);
      7'h61:   word_d = make_word(6'd41, 6'd8);
      7'h62:   word_d = make_word(6'd42, 6'd9);
      7'h63:   word_d = make_word(6'd43, 6'd10);
      7'h64:   word_d = make_word(6'd44, 6'd0);
      default: begin
        if (addr[ADDR_W-1 -: SONG_W] == SONG_W'(1)) begin
          word_d = make_word(NOTE_W'(addr[IDX_W-1:0]) + NOTE_W'(1),
                             DUR_W'(addr[2:0]) + DUR_W'(1));
        end
      end
    endcase
  end

  // Registered read port gives the one cycle ROM latency.
  always_ff @(posedge clk) begin
    dout_q <= word_d;
  end

  assign dout = dout_q;

endmodule

// File: rtl/song_sequencer.sv
// Steps through a song in the ROM, hands each word to the note player and waits for it to finish.
module song_sequencer
  import song_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              play,
  input  logic [SONG_W-1:0] song_sel,
  input  logic              restart,
  input  logic              note_done,
  output logic [NOTE_W-1:0] note_out,
  output logic [DUR_W-1:0]  duration_out,
  output logic              load_note,
  output logic              song_done,
  output logic [IDX_W-1:0]  note_index
);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [SONG_W-1:0] song_q, song_d;
  logic [NOTE_W-1:0] note_q, note_d;
  logic [DUR_W-1:0]  dur_q, dur_d;
  logic              load_q, load_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] rom_addr;
  logic [WORD_W-1:0] rom_data;
  logic              reseq;

  assign rom_addr = {song_q, idx_q};

  song_rom u_rom (
    .clk  (clk),
    .addr (rom_addr),
    .dout (rom_data)
  );

  // A restart pulse or a new song request rewinds to word 0 from any active state.
  assign reseq = (state_q != S_IDLE) && (restart || (song_sel != song_q));

  // Next-state logic; with play low every transition freezes except finishing an already fetched load.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    song_d  = song_q;
    note_d  = note_q;
    dur_d   = dur_q;
    load_d  = 1'b0;
    if (reseq) begin
      idx_d   = '0;
      song_d  = song_sel;
      state_d = play ? S_FETCH : S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          song_d = song_sel;
          if (play) state_d = S_FETCH;
        end
        S_FETCH: begin
          if (play) state_d = S_LOAD_WAIT;
        end
        S_LOAD_WAIT: begin
          if (is_terminator(rom_data)) begin
            state_d = S_DONE;
          end else begin
            note_d  = rom_data[WORD_W-1 -: NOTE_W];
            dur_d   = rom_data[DUR_W-1:0];
            load_d  = 1'b1;
            state_d = S_CLR_WAIT;
          end
        end
        S_CLR_WAIT: begin
          if (play && !note_done) state_d = S_PLAYING;
        end
        S_PLAYING: begin
          if (play && note_done) state_d = S_ADVANCE;
        end
        S_ADVANCE: begin
          if (play) begin
            if (idx_q == IDX_LAST) begin
              state_d = S_DONE;
            end else begin
              idx_d   = idx_q + IDX_W'(1);
              state_d = S_FETCH;
            end
          end
        end
        S_DONE: begin
          state_d = S_DONE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
    done_d = (state_d == S_DONE);
  end

  // All sequencer registers, cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      song_q  <= '0;
      note_q  <= '0;
      dur_q   <= '0;
      load_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      song_q  <= song_d;
      note_q  <= note_d;
      dur_q   <= dur_d;
      load_q  <= load_d;
      done_q  <= done_d;
    end
  end

  assign note_out     = note_q;
  assign duration_out = dur_q;
  assign load_note    = load_q;
  assign song_done    = done_q;
  assign note_index   = idx_q;

endmodule
